// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// The slice functions decide which lookahead groups each middle stage resolves.
package cla_pkg;
   localparam int MAX_STAGES = 4;

   function automatic bit legal_block(int blk);
      return (blk == 2) || (blk == 4) || (blk == 8);
   endfunction

   function automatic int group_count(int width, int blk);
      return width / blk;
   endfunction

   // Exclusive upper group index resolved by slice k of nslices, LSB first.
   function automatic int slice_end(int k, int ng, int nslices);
      return ((k + 1) * ng) / nslices;
   endfunction

   function automatic int slice_lo(int k, int ng, int nslices);
      return (k == 0) ? 0 : slice_end(k - 1, ng, nslices);
   endfunction
endpackage

// File: rtl/cla_group.sv
// One BLOCK-bit lookahead group: group generate/propagate plus local sum bits.
module cla_group
   import cla_pkg::*;
#(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic             grp_g,
   output logic             grp_p,
   output logic [BLOCK-1:0] s
);
   logic [BLOCK-1:0] g, p, c;

   if (!legal_block(BLOCK)) begin : g_bad_block
      $error("cla_group: BLOCK must be 2, 4 or 8");
   end

   assign g = a & b;
   assign p = a | b;

   always_comb begin
      c     = '0;
      c[0]  = ci;
      grp_g = 1'b0;
      for (int j = 0; j < BLOCK; j++) begin
         if (j < BLOCK - 1) c[j+1] = g[j] | (p[j] & c[j]);
         grp_g = g[j] | (p[j] & grp_g);
      end
   end

   assign grp_p = &p;
   assign s     = a ^ b ^ c;
endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with an elastic valid/ready pipeline.
// Stage 1 holds group G/P; middle stages resolve group carries; the last registers results.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);
   localparam int NG   = group_count(WIDTH, BLOCK);
   localparam int NMID = (STAGES > 2) ? STAGES - 2 : 1;
   localparam int DONE = (STAGES > 2) ? NG : 0;

   if (!legal_block(BLOCK) || (WIDTH % BLOCK) != 0 || STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_param
      $error("cla_adder_pipe: illegal WIDTH/BLOCK/STAGES combination");
   end

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [NG-1:0]    g;
      logic [NG-1:0]    p;
      logic [NG:0]      c;   // c[i] = carry into group i, valid once resolved
   } pay_t;

   function automatic logic [NG:0] carries(pay_t x, int lo, int hi);
      logic [NG:0] c;
      c = x.c;
      for (int i = 0; i < NG; i++)
         if (i >= lo && i < hi) c[i+1] = x.g[i] | (x.p[i] & c[i]);
      return c;
   endfunction

   logic [WIDTH-1:0] b_eff, unused_fs, s_nxt;
   logic [NG-1:0]    fg, fp, unused_bg, unused_bp;
   logic [NG:0]      cfin;
   pay_t             pay0, last_in;

   assign b_eff = sub ? ~b : b;

   always_comb begin
      pay0      = '0;
      pay0.a    = a;
      pay0.b    = b_eff;
      pay0.g    = fg;
      pay0.p    = fp;
      pay0.c[0] = sub | cin;
   end

   // Flow control: a stage loads when empty or when its successor moves.
   logic [STAGES:1] vld_pipe, ld;
   logic [STAGES:0] vld_src;
   logic            ld_chain;

   assign vld_src   = {vld_pipe, in_valid};
   assign in_ready  = ld[1];
   assign out_valid = vld_pipe[STAGES];

   always_comb begin
      ld_chain = out_ready;
      ld       = '0;
      for (int k = STAGES; k >= 1; k--) begin
         ld_chain = ~vld_pipe[k] | ld_chain;
         ld[k]    = ld_chain;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe <= '0;
      else
         for (int k = 1; k <= STAGES; k++)
            if (ld[k]) vld_pipe[k] <= vld_src[k-1];
   end

   if (STAGES == 1) begin : g_comb
      assign last_in = pay0;
   end else begin : g_regs
      pay_t stg [1:STAGES-1];
      always_ff @(posedge clk) begin
         if (ld[1] & in_valid) stg[1] <= pay0;
         for (int k = 2; k < STAGES; k++)
            if (ld[k] & vld_pipe[k-1]) begin
               stg[k]   <= stg[k-1];
               stg[k].c <= carries(stg[k-1], slice_lo(k-2, NG, NMID), slice_end(k-2, NG, NMID));
            end
      end
      assign last_in = stg[STAGES-1];
   end

   assign cfin = carries(last_in, DONE, NG);

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_front (
         .a(a[gi*BLOCK +: BLOCK]), .b(b_eff[gi*BLOCK +: BLOCK]), .ci(1'b0),
         .grp_g(fg[gi]), .grp_p(fp[gi]), .s(unused_fs[gi*BLOCK +: BLOCK]));
      cla_group #(.BLOCK(BLOCK)) u_back (
         .a(last_in.a[gi*BLOCK +: BLOCK]), .b(last_in.b[gi*BLOCK +: BLOCK]), .ci(cfin[gi]),
         .grp_g(unused_bg[gi]), .grp_p(unused_bp[gi]), .s(s_nxt[gi*BLOCK +: BLOCK]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (ld[STAGES] & vld_src[STAGES-1]) begin
         sum      <= s_nxt;
         cout     <= cfin[NG];
         overflow <= (last_in.a[WIDTH-1] == last_in.b[WIDTH-1]) && (s_nxt[WIDTH-1] != last_in.a[WIDTH-1]);
         zero     <= ~|s_nxt;
      end
   end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and random checks of cla_adder_pipe with a queue scoreboard per instance.
module tb_cla_adder_pipe;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a = '0, b = '0;
   logic        cin = 1'b0, sub = 1'b0;

   logic        m_iv, m_ir, m_ov, m_or, m_cout, m_ovf, m_zero;
   logic [31:0] m_sum;

   logic        r_iv;
   logic        r_ir [3], r_ov [3], r_or [3], r_cout [3], r_ovf [3], r_zero [3];
   logic [31:0] r_sum [3];

   int checks = 0, errors = 0;
   logic [34:0] mq [$];
   logic [34:0] rq [3][$];

   cla_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_main (
      .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(m_ov), .out_ready(m_or), .sum(m_sum), .cout(m_cout), .overflow(m_ovf), .zero(m_zero));
   cla_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(1)) u_r0 (
      .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir[0]), .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(r_ov[0]), .out_ready(r_or[0]), .sum(r_sum[0]), .cout(r_cout[0]), .overflow(r_ovf[0]), .zero(r_zero[0]));
   cla_adder_pipe #(.WIDTH(32), .BLOCK(8), .STAGES(3)) u_r1 (
      .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir[1]), .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(r_ov[1]), .out_ready(r_or[1]), .sum(r_sum[1]), .cout(r_cout[1]), .overflow(r_ovf[1]), .zero(r_zero[1]));
   cla_adder_pipe #(.WIDTH(32), .BLOCK(2), .STAGES(4)) u_r2 (
      .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir[2]), .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(r_ov[2]), .out_ready(r_or[2]), .sum(r_sum[2]), .cout(r_cout[2]), .overflow(r_ovf[2]), .zero(r_zero[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fail_empty(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=result expected=no_result", tag);
   endtask

   // Reference: {cout, overflow, zero, sum}; overflow judged from the true signed result.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
      logic [32:0] r;
      longint sx, sy, se;
      logic o;
      r  = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y} + {32'd0, ci});
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      se = s ? (sx - sy) : (sx + sy + longint'(ci));
      o  = (se > 64'sd2147483647) || (se < -64'sd2147483648);
      return {r[32], o, (r[31:0] == 32'd0), r[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic m_pop(input string tag);
      logic [34:0] e;
      if (mq.size() == 0) fail_empty({tag, "_underflow"});
      else begin
         e = mq.pop_front();
         chk(tag, {29'd0, m_cout, m_ovf, m_zero, m_sum}, {29'd0, e});
      end
   endtask

   task automatic r_pop(input int i);
      logic [34:0] e;
      if (rq[i].size() == 0) fail_empty($sformatf("rand%0d_underflow", i));
      else begin
         e = rq[i].pop_front();
         chk($sformatf("rand%0d", i), {29'd0, r_cout[i], r_ovf[i], r_zero[i], r_sum[i]}, {29'd0, e});
      end
   endtask

   // Single bundle into the main instance; checks 2-cycle latency and the exact result.
   task automatic m_case(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic s, input logic [34:0] exp);
      @(negedge clk);
      a = x; b = y; cin = ci; sub = s; m_iv = 1'b1;
      #1 chk({tag, "_in_ready"}, m_ir, 1);
      @(negedge clk);
      m_iv = 1'b0;
      chk({tag, "_not_early"}, m_ov, 0);
      @(negedge clk);
      chk({tag, "_valid"}, m_ov, 1);
      chk(tag, {29'd0, m_cout, m_ovf, m_zero, m_sum}, {29'd0, exp});
   endtask

   initial begin
      int nxt, got, stale;
      int lat [3];
      int exp_lat [3];
      logic [31:0] held;
      logic hold_v;
      exp_lat = '{1, 3, 4};
      m_iv = 1'b0; m_or = 1'b1; r_iv = 1'b0;
      for (int i = 0; i < 3; i++) r_or[i] = 1'b1;

      #1 rst = 1'b1;
      #10;
      chk("rst_out_valid", m_ov, 0);
      chk("rst_sum", m_sum, 0);
      chk("rst_flags", {m_cout, m_ovf, m_zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_in_ready", m_ir, 1);

      m_case("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
      m_case("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
      m_case("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
      m_case("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});

      // Backpressure: 8 bundles a=b=i, out_ready low for cycles 3..5.
      nxt = 0; got = 0; hold_v = 1'b0; held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         m_or = !(c >= 3 && c <= 5);
         m_iv = (nxt < 8);
         a = nxt; b = nxt; cin = 1'b0; sub = 1'b0;
         #1;
         if (hold_v && m_ov) chk("stall_hold", m_sum, held);
         hold_v = m_ov && !m_or;
         held   = m_sum;
         if (c == 4) chk("full_in_ready", m_ir, 0);
         if (m_ov && m_or) begin
            chk("bp_sum_value", m_sum, 2 * got);
            m_pop("bp_out");
            got++;
         end
         if (m_iv && m_ir) begin
            mq.push_back(model(nxt, nxt, 1'b0, 1'b0));
            nxt++;
         end
      end
      m_iv = 1'b0; m_or = 1'b1;
      chk("bp_count", got, 8);
      chk("bp_queue_empty", mq.size(), 0);

      // Reset with two bundles in flight.
      @(negedge clk);
      a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; m_iv = 1'b1;
      @(negedge clk);
      a = 32'h33; b = 32'h44;
      @(negedge clk);
      m_iv = 1'b0;
      chk("pre_rst_valid", m_ov, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", m_ov, 0);
      chk("midrst_sum", m_sum, 0);
      #1 rst = 1'b0;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (m_ov) stale = 1;
      end
      chk("post_rst_in_ready", m_ir, 1);
      chk("post_rst_no_stale", stale, 0);

      // Latency of the random-regression instances.
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; sub = 1'b0; r_iv = 1'b1;
      for (int i = 0; i < 3; i++) rq[i].push_back(model(a, b, cin, sub));
      @(negedge clk);
      r_iv = 1'b0;
      lat = '{0, 0, 0};
      for (int c = 1; c <= 6; c++) begin
         for (int i = 0; i < 3; i++)
            if (r_ov[i]) begin
               if (lat[i] == 0) lat[i] = c;
               r_pop(i);
            end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) chk($sformatf("latency%0d", i), lat[i], exp_lat[i]);

      // Random regression with random backpressure per instance.
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) r_or[i] = ($urandom_range(0, 3) != 0);
         a = pick(); b = pick();
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         #1;
         r_iv = ($urandom_range(0, 4) != 0) && r_ir[0] && r_ir[1] && r_ir[2];
         for (int i = 0; i < 3; i++) if (r_ov[i] && r_or[i]) r_pop(i);
         if (r_iv) for (int i = 0; i < 3; i++) rq[i].push_back(model(a, b, cin, sub));
      end
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         r_iv = 1'b0;
         for (int i = 0; i < 3; i++) r_or[i] = 1'b1;
         #1;
         for (int i = 0; i < 3; i++) if (r_ov[i]) r_pop(i);
      end
      for (int i = 0; i < 3; i++) chk($sformatf("rand%0d_drained", i), rq[i].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
